decoder_scan_ctrl: RTL

- Upstream sequencer for the 3-to-8 decoder stage.
- Steps a registered select code (sel) through the enabled channels, holding each for a programmable dwell time, and drives the decoder enable (en).
- Supports single-shot and continuous scanning, a channel mask, and a start/stop/done handshake to the controlling logic.

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_next_ch.sv | 29 ++
 rtl/decoder_scan_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared constants and state type for the decoder scan controller.
// Imported by the scan sequencer and its channel search helper.
package scan_pkg;

  localparam int SEL_W       = 3;
  localparam int N_CH        = 8;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Channel search: next enabled index above cur, and lowest enabled index.
// Purely combinational; serves both the start and the advance decisions.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next_idx,
  output logic             next_found,
  output logic [SEL_W-1:0] first_idx
);

  // Walk high to low so the last hit is the lowest qualifying index
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    first_idx  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = SEL_W'(i);
        if (SEL_W'(i) > cur) begin
          next_idx   = SEL_W'(i);
          next_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for the 3-to-8 decoder: steps sel over enabled
// channels with a programmable dwell, single-shot or continuous.
module decoder_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_done;
  logic [DWELL_W-1:0] r_cnt;
  logic [N_CH-1:0]    r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_cont;

  state_t             w_state;
  logic [SEL_W-1:0]   w_sel;
  logic               w_done;
  logic [DWELL_W-1:0] w_cnt;
  logic [N_CH-1:0]    w_mask;
  logic [DWELL_W-1:0] w_dwell;
  logic               w_cont;

  logic [N_CH-1:0]    w_srch_mask;
  logic [SEL_W-1:0]   w_next_idx;
  logic               w_next_found;
  logic [SEL_W-1:0]   w_first_idx;

  // Idle looks at the live mask for the first channel; scan uses the shadow
  assign w_srch_mask = (r_state == IDLE) ? ch_mask : r_mask;

  scan_next_ch u_next (
    .mask       (w_srch_mask),
    .cur        (r_sel),
    .next_idx   (w_next_idx),
    .next_found (w_next_found),
    .first_idx  (w_first_idx)
  );

  // Register all state; en and busy both follow the registered state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_dwell <= '0;
      r_cont  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
      r_mask  <= w_mask;
      r_dwell <= w_dwell;
      r_cont  <= w_cont;
    end
  end

  // Next-state: start capture, dwell counting, advance/wrap, stop/finish
  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_mask  = r_mask;
    w_dwell = r_dwell;
    w_cont  = r_cont;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (|ch_mask) begin
            w_mask  = ch_mask;
            w_dwell = dwell;
            w_cont  = continuous;
            w_sel   = w_first_idx;
            w_cnt   = '0;
            w_state = SCAN;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          w_state = IDLE;
          w_sel   = '0;
          w_cnt   = '0;
          w_done  = 1'b1;
        end else if (r_cnt != r_dwell) begin
          w_cnt = r_cnt + DWELL_W'(1);
        end else if (w_next_found) begin
          w_sel = w_next_idx;
          w_cnt = '0;
        end else if (r_cont) begin
          w_sel = w_first_idx;
          w_cnt = '0;
        end else begin
          w_state = IDLE;
          w_sel   = '0;
          w_cnt   = '0;
          w_done  = 1'b1;
        end
      end
    endcase
  end

  assign sel  = r_sel;
  assign en   = (r_state == SCAN);
  assign busy = (r_state == SCAN);
  assign done = r_done;

endmodule
